load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: AddressWidth, default 10, byte-address width of the data port.
REQ-002 Parameter: TimeoutCycles, default 16, maximum BUSY cycles waiting for bus_ack_i (range 2..255).
REQ-003 Reset is asynchronous and active-low; one clock.
REQ-004 clk_i  input  1  core clock, all state on rising edge.
REQ-005 rst_i  input  1  asynchronous active-low reset.
REQ-006 mem_r_en_i  input  1  load request from datapath.
REQ-007 mem_wr_en_i  input  1  store request from datapath.
REQ-008 funct3_i  input  3  access size/sign code (instr[14:12]).
REQ-009 addr_i  input  AddressWidth  byte address (ALU result).
REQ-010 wr_data_i  input  32  store data (rs2).
REQ-011 r_data_o  output  32  extended load data to the writeback mux.
REQ-012 stall_o  output  1  freeze PC and regfile write while high.
REQ-013 fault_o  output  1  one-cycle pulse: misaligned, illegal funct3 or timeout.
REQ-014 bus_req_o  output  1  bus request, held until acknowledged.
REQ-015 bus_we_o  output  1  1 = write, 0 = read.
REQ-016 bus_addr_o  output  AddressWidth  word-aligned address {addr_i[AW-1:2],2'b00}.
REQ-017 bus_be_o  output  4  byte enables.
REQ-018 bus_wdata_o  output  32  lane-positioned store data.
REQ-019 bus_rdata_i  input  32  read word, valid with bus_ack_i.
REQ-020 bus_ack_i  input  1  single-cycle completion from bus.

Function
REQ-021 FSM states: IDLE, BUSY, DONE.
REQ-022 Access = mem_r_en_i | mem_wr_en_i; when both are high, the access is a write.
REQ-023 Legal funct3: loads 000/001/010/100/101; stores 000/001/010; any other code is illegal.
REQ-024 Misaligned: halfword with addr[0]=1; word with addr[1:0]!=00.
REQ-025 IDLE, access, legal and aligned: stall_o=1 combinationally in the same cycle; latch we/addr/be/wdata/funct3/addr[1:0]; next state BUSY.
REQ-026 IDLE, access, illegal or misaligned: no bus request, stall_o=0, fault_o=1 for that cycle, r_data_o=0; state stays IDLE.
REQ-027 BUSY: bus_req_o=1 and stall_o=1; bus outputs are driven from latched values and stay stable until ack.
REQ-028 BUSY with bus_ack_i=1: capture the extended read data (reads only); next state DONE.
REQ-029 Timeout counter: cleared on IDLE->BUSY, increments each BUSY cycle without ack. On reaching TimeoutCycles-1: next state DONE, fault_o=1 in DONE, r_data_o=0.
REQ-030 Ack and timeout in the same cycle: ack wins, no fault.
REQ-031 DONE: stall_o=0, bus_req_o=0, r_data_o holds the captured value for exactly this cycle; next state IDLE unconditionally.
REQ-032 Minimum access latency is 2 cycles of stall (ack on the first BUSY cycle), with the result in the third cycle.
REQ-033 Byte enables: SB/LB/LBU be=0001<<addr[1:0]; SH/LH/LHU be=0011 (addr[1]=0) or 1100; word be=1111.
REQ-034 Store data: SB replicates wr_data_i[7:0] to all four lanes; SH replicates [15:0] to both halves; SW passes through.
REQ-035 Load extraction selects the lane by latched addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
REQ-036 Writes return r_data_o=0 in DONE.
REQ-037 bus_ack_i in IDLE or DONE is ignored.

Reset
REQ-038 On rst_i=0, asynchronously force: state IDLE, bus_req_o=0, bus_we_o=0, bus_be_o=0, bus_addr_o=0, bus_wdata_o=0, r_data_o=0, fault_o=0, timeout counter=0.
REQ-039 Reset mid-BUSY abandons the access; the first access after release starts from IDLE.
REQ-040 stall_o while rst_i=0 is 0.

Verification
REQ-041 LW addr=0x010, ack on 3rd BUSY cycle, rdata=0xDEADBEEF -> stall_o high 4 cycles, bus_be_o=1111, bus_addr_o=0x010, r_data_o=0xDEADBEEF in DONE.
REQ-042 LB addr=0x013, rdata=0x80FF7F01 -> be=1000, r_data_o=0xFFFFFF80; LBU same -> 0x00000080.
REQ-043 SH addr=0x006, wr_data=0x1234ABCD -> bus_we_o=1, be=1100, bus_wdata_o=0xABCDABCD, bus_addr_o=0x004.
REQ-044 LW addr=0x002 -> fault_o pulse, stall_o=0, bus_req_o never asserted; funct3=011 -> same response.
REQ-045 SW with no ack, TimeoutCycles=16 -> 16 BUSY cycles, DONE with fault_o=1, then IDLE; late ack ignored.
REQ-046 rst_i low during BUSY -> bus_req_o=0 before the next clock edge; subsequent LW completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: turns datapath load/store requests into single-beat bus
// accesses, with byte-lane steering, load extension, fault detection and a bus timeout.
module load_store_unit #(
   parameter int AddressWidth  = 10,
   parameter int TimeoutCycles = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    mem_r_en_i,
   input  logic                    mem_wr_en_i,
   input  logic [2:0]              funct3_i,
   input  logic [AddressWidth-1:0] addr_i,
   input  logic [31:0]             wr_data_i,
   output logic [31:0]             r_data_o,
   output logic                    stall_o,
   output logic                    fault_o,
   output logic                    bus_req_o,
   output logic                    bus_we_o,
   output logic [AddressWidth-1:0] bus_addr_o,
   output logic [3:0]              bus_be_o,
   output logic [31:0]             bus_wdata_o,
   input  logic [31:0]             bus_rdata_i,
   input  logic                    bus_ack_i
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [7:0] TO_LAST = 8'(TimeoutCycles - 1);

   state_t                  r_state;
   logic                    r_we;
   logic [AddressWidth-1:0] r_addr;
   logic [3:0]              r_be;
   logic [31:0]             r_wdata;
   logic [2:0]              r_funct3;
   logic [1:0]              r_lane;
   logic [7:0]              r_cnt;
   logic [31:0]             r_rdata;
   logic                    r_timeout;

   logic        w_access;
   logic        w_legal;
   logic        w_misal;
   logic        w_start;
   logic        w_bad;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_ext;

   // A simultaneous read and write request is treated as a write.
   assign w_access = mem_r_en_i | mem_wr_en_i;

   always_comb begin
      w_legal = 1'b0;
      case (funct3_i)
         3'b000, 3'b001, 3'b010: w_legal = 1'b1;
         3'b100, 3'b101:         w_legal = ~mem_wr_en_i;
         default:                w_legal = 1'b0;
      endcase
   end

   always_comb begin
      w_misal = 1'b0;
      case (funct3_i[1:0])
         2'b01:   w_misal = addr_i[0];
         2'b10:   w_misal = |addr_i[1:0];
         default: w_misal = 1'b0;
      endcase
   end

   assign w_start = (r_state == IDLE) && w_access && w_legal && !w_misal;
   assign w_bad   = (r_state == IDLE) && w_access && !(w_legal && !w_misal);

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = wr_data_i;
      case (funct3_i[1:0])
         2'b00: begin
            w_be    = 4'b0001 << addr_i[1:0];
            w_wdata = {4{wr_data_i[7:0]}};
         end
         2'b01: begin
            w_be    = addr_i[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{wr_data_i[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = wr_data_i;
         end
      endcase
   end

   // Lane selection uses the latched address so the bus word can arrive any time.
   always_comb begin
      w_byte = bus_rdata_i[7:0];
      case (r_lane)
         2'd0: w_byte = bus_rdata_i[7:0];
         2'd1: w_byte = bus_rdata_i[15:8];
         2'd2: w_byte = bus_rdata_i[23:16];
         2'd3: w_byte = bus_rdata_i[31:24];
         default: w_byte = bus_rdata_i[7:0];
      endcase
      w_half = r_lane[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
      case (r_funct3)
         3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
         3'b100:  w_ext = {24'd0, w_byte};
         3'b001:  w_ext = {{16{w_half[15]}}, w_half};
         3'b101:  w_ext = {16'd0, w_half};
         default: w_ext = bus_rdata_i;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state   <= IDLE;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_be      <= 4'd0;
         r_wdata   <= 32'd0;
         r_funct3  <= 3'd0;
         r_lane    <= 2'd0;
         r_cnt     <= 8'd0;
         r_rdata   <= 32'd0;
         r_timeout <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_we      <= mem_wr_en_i;
                  r_addr    <= {addr_i[AddressWidth-1:2], 2'b00};
                  r_be      <= w_be;
                  r_wdata   <= w_wdata;
                  r_funct3  <= funct3_i;
                  r_lane    <= addr_i[1:0];
                  r_cnt     <= 8'd0;
                  r_rdata   <= 32'd0;
                  r_timeout <= 1'b0;
                  r_state   <= BUSY;
               end
            end
            BUSY: begin
               // An ack on the final allowed cycle still completes cleanly.
               if (bus_ack_i) begin
                  if (!r_we) r_rdata <= w_ext;
                  r_state <= DONE;
               end else if (r_cnt == TO_LAST) begin
                  r_timeout <= 1'b1;
                  r_rdata   <= 32'd0;
                  r_state   <= DONE;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            DONE: begin
               r_timeout <= 1'b0;
               r_state   <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign stall_o     = rst_i & (w_start | (r_state == BUSY));
   assign fault_o     = (rst_i & w_bad) | ((r_state == DONE) & r_timeout);
   assign r_data_o    = (r_state == DONE) ? r_rdata : 32'd0;
   assign bus_req_o   = (r_state == BUSY);
   assign bus_we_o    = r_we;
   assign bus_addr_o  = r_addr;
   assign bus_be_o    = r_be;
   assign bus_wdata_o = r_wdata;

endmodule
